// File: rtl/alu_operand_loader.sv
// Button/switch front end for the 8-bit ALU: debounced presses load A -> B -> opcode in order.
// Optional saturating error counter on o_err_count when ALU_LOADER_ERRCNT_EN is defined.
module alu_operand_loader #(
  parameter int unsigned BUS_SIZE        = 8,
  parameter int unsigned OPCODE_SIZE     = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic                   i_boton1,
  input  logic                   i_boton2,
  input  logic                   i_boton3,
  input  logic [BUS_SIZE-1:0]    i_swiches,
  output logic [BUS_SIZE-1:0]    o_datoA,
  output logic [BUS_SIZE-1:0]    o_datoB,
  output logic [OPCODE_SIZE-1:0] o_opcode,
  output logic                   o_valid,
  output logic [1:0]             o_state,
`ifdef ALU_LOADER_ERRCNT_EN
  output logic                   o_seq_error,
  output logic [7:0]             o_err_count
`else
  output logic                   o_seq_error
`endif
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [OPCODE_SIZE-1:0] OP_RESET = OPCODE_SIZE'(6'b100000);

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    WAIT_OP = 2'd2
  } state_t;

  logic [2:0] raw;
  logic [2:0] press;

  assign raw = {i_boton3, i_boton2, i_boton1};

  // Per button: 2-FF synchroniser, stability counter, rising-edge detect on the clean level.
  for (genvar g = 0; g < 3; g++) begin : g_btn
    logic             sync1;
    logic             sync2;
    logic             deb;
    logic             deb_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
        sync1 <= 1'b0;
        sync2 <= 1'b0;
        deb   <= 1'b0;
        deb_q <= 1'b0;
        cnt   <= '0;
      end else begin
        sync1 <= raw[g];
        sync2 <= sync1;
        deb_q <= deb;
        if (sync2 == deb) begin
          cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          deb <= sync2;
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

    assign press[g] = deb & ~deb_q;
  end

  state_t                 state;
  state_t                 state_next;
  logic [BUS_SIZE-1:0]    a_next;
  logic [BUS_SIZE-1:0]    b_next;
  logic [OPCODE_SIZE-1:0] op_next;
  logic                   valid_next;
  logic                   err_next;

  // Only the expected button advances; any other pulse in the same cycle flags an error.
  always_comb begin
    state_next = state;
    a_next     = o_datoA;
    b_next     = o_datoB;
    op_next    = o_opcode;
    valid_next = 1'b0;
    err_next   = 1'b0;
    case (state)
      WAIT_A: begin
        err_next = press[1] | press[2];
        if (press[0]) begin
          a_next     = i_swiches;
          state_next = WAIT_B;
        end
      end
      WAIT_B: begin
        err_next = press[0] | press[2];
        if (press[1]) begin
          b_next     = i_swiches;
          state_next = WAIT_OP;
        end
      end
      WAIT_OP: begin
        err_next = press[0] | press[1];
        if (press[2]) begin
          op_next    = i_swiches[OPCODE_SIZE-1:0];
          valid_next = 1'b1;
          state_next = WAIT_A;
        end
      end
      default: state_next = WAIT_A;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= WAIT_A;
      o_datoA     <= '0;
      o_datoB     <= '0;
      o_opcode    <= OP_RESET;
      o_valid     <= 1'b0;
      o_seq_error <= 1'b0;
    end else begin
      state       <= state_next;
      o_datoA     <= a_next;
      o_datoB     <= b_next;
      o_opcode    <= op_next;
      o_valid     <= valid_next;
      o_seq_error <= err_next;
    end
  end

  assign o_state = state;

`ifdef ALU_LOADER_ERRCNT_EN
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_err_count <= 8'd0;
    end else if (err_next && (o_err_count != 8'hFF)) begin
      o_err_count <= o_err_count + 8'd1;
    end
  end
`endif

endmodule
